cfg_cmd_dispatch: RTL and testbench
===================================

// Module: cfg_cmd_dispatch
// PURPOSE
//  Sequences the cfg_UART command/response channel.
//  - Captures each 24-bit frame (frm_rdy/cfg_data) and releases it with a clr_frm_rdy pulse.
//  - Decodes a target index and forwards the command to one of NUM_TGT register-bank targets over req/ack.
//  - Returns the target's 16-bit result, or an error code, through snd_rsp/rsp_data.
//  - Sits between cfg_UART and the config/status targets; it is the only driver of clr_frm_rdy and snd_rsp.
// PARAMETERS
//  NUM_TGT  4        number of targets, 1..4 (index field is fixed at 2 bits)
//  TIMEOUT  1000     cycles allowed in ISSUE before timeout, 2..1023
//  ERR_TGT  16'hEE01 response for target index >= NUM_TGT
//  ERR_TO   16'hEE02 response on ack timeout
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  frm_rdy      in   1          cfg_UART frame valid, held until clr_frm_rdy
//  cfg_data     in   24         frame: [23:22] target idx, [21:16] cmd, [15:0] data
//  clr_frm_rdy  out  1          one-cycle pulse releasing the frame
//  snd_rsp      out  1          one-cycle pulse starting the 2-byte response
//  rsp_data     out  16         response word, registered, held stable until next RESP
//  tgt_req      out  NUM_TGT    one-hot request, level, held until ack/timeout
//  tgt_cmd      out  6          latched cmd field, valid while any tgt_req is high
//  tgt_data     out  16         latched data field, valid while any tgt_req is high
//  tgt_ack      in   NUM_TGT    per-target ack, single-cycle
//  tgt_rsp      in   16*NUM_TGT per-target result, slice [16*i+15:16*i], sampled on ack
//  busy         out  1          high whenever state != IDLE
//  frm_cnt      out  8          frames accepted, wraps 255->0
//  err_cnt      out  8          error responses sent (ERR_TGT or ERR_TO), saturates at 255
// BEHAVIOUR
//  Reset
//   - state=IDLE; rsp_data=0, frm_cnt=0, err_cnt=0, timeout count=0.
//   - All pulse/request outputs 0.
//   - Reset asserted mid-transaction drops tgt_req at that edge; no snd_rsp is issued.
//  FSM (registered state; outputs decoded from state and registers)
//   IDLE:  frm_rdy=1 -> latch cfg_data into cmd_reg, frm_cnt+1, go CLR.
//   CLR:   clr_frm_rdy=1.
//          - idx < NUM_TGT -> clear timeout count, go ISSUE.
//          - else -> rsp_data<=ERR_TGT, err_cnt+1, go RESP.
//   ISSUE: tgt_req[idx]=1; tgt_cmd/tgt_data driven from cmd_reg; timeout count +1 per cycle.
//          - tgt_ack[idx]=1 -> rsp_data<=tgt_rsp slice idx, go RESP.
//          - else if count==TIMEOUT-1 -> rsp_data<=ERR_TO, err_cnt+1, go RESP.
//          - Ack on the timeout cycle: ack wins; no error.
//          - Acks from non-selected targets are ignored.
//   RESP:  snd_rsp=1 for exactly one cycle, then go IDLE.
//  Timing
//   - Accept to release: frm_rdy seen at edge N -> clr_frm_rdy high in cycle N+1.
//   - Min frame-to-snd_rsp latency is 3 cycles (ack on first ISSUE cycle).
//   - tgt_req rises in the cycle after CLR. Bad-target path: snd_rsp 2 cycles after accept.
//  Rules
//   - rsp_data must not change between RESP and the next ISSUE/CLR update.
//     cfg_UART reads the high byte after the snd_rsp edge.
//   - frm_rdy is sampled only in IDLE. A frame arriving while busy waits, because cfg_UART holds it.
//   - tgt_cmd/tgt_data may show cmd_reg at all times; targets qualify them with tgt_req.
//   - At most one tgt_req bit is high; never any in IDLE/CLR/RESP.
//   - Unused state encodings go to IDLE.
// TESTING
//  1. cfg_data=24'h4A_1234 (idx1, cmd 0x0A), tgt_ack[1] 2 cycles after req, tgt_rsp[31:16]=16'hBEEF
//     -> clr_frm_rdy 1 cycle; tgt_req=4'b0010, tgt_cmd=6'h0A, tgt_data=16'h1234;
//        snd_rsp 1 cycle; rsp_data=16'hBEEF; frm_cnt=1.
//  2. NUM_TGT=2, cfg_data idx=3
//     -> no tgt_req ever; snd_rsp 2 cycles after accept; rsp_data=16'hEE01; err_cnt=1.
//  3. idx0, never ack
//     -> tgt_req[0] high exactly TIMEOUT cycles then low; rsp_data=16'hEE02; err_cnt+1.
//     Repeat with ack on the last cycle -> rsp_data=tgt_rsp[15:0], err_cnt unchanged.
//  4. tgt_ack[2] pulsed while idx=0 is active -> ignored; rsp_data from target 0 only.
//  5. rst pulsed mid-ISSUE -> next cycle tgt_req=0, busy=0, counters 0, no snd_rsp.
//     A following frame completes normally.
//  6. 256 back-to-back frames, plus 300 forced bad-target frames
//     -> frm_cnt wraps to 0 at 256; err_cnt saturates at 255.

Source files
------------

// File: rtl/cfg_cmd_dispatch_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : cfg_cmd_dispatch_if
// Purpose  : cfg_UART frame/response channel plus target req/ack bus.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
interface cfg_cmd_dispatch_if #(
   parameter int NUM_TGT = 4
);
   logic                   frm_rdy;
   logic [23:0]            cfg_data;
   logic                   clr_frm_rdy;
   logic                   snd_rsp;
   logic [15:0]            rsp_data;
   logic [NUM_TGT-1:0]     tgt_req;
   logic [5:0]             tgt_cmd;
   logic [15:0]            tgt_data;
   logic [NUM_TGT-1:0]     tgt_ack;
   logic [16*NUM_TGT-1:0]  tgt_rsp;
   logic                   busy;
   logic [7:0]             frm_cnt;
   logic [7:0]             err_cnt;

   modport master (
      input  frm_rdy, cfg_data, tgt_ack, tgt_rsp,
      output clr_frm_rdy, snd_rsp, rsp_data, tgt_req, tgt_cmd, tgt_data,
             busy, frm_cnt, err_cnt
   );

   modport slave (
      output frm_rdy, cfg_data, tgt_ack, tgt_rsp,
      input  clr_frm_rdy, snd_rsp, rsp_data, tgt_req, tgt_cmd, tgt_data,
             busy, frm_cnt, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/cfg_cmd_dispatch.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : cfg_cmd_dispatch
// Purpose  : Captures cfg_UART frames, forwards them to one target, returns result.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module cfg_cmd_dispatch #(
   parameter int          NUM_TGT = 4,
   parameter int          TIMEOUT = 1000,
   parameter logic [15:0] ERR_TGT = 16'hEE01,
   parameter logic [15:0] ERR_TO  = 16'hEE02
) (
   input  wire logic             clk,
   input  wire logic             rst,
   cfg_cmd_dispatch_if.master    bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLR   = 2'd1,
      ST_ISSUE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [23:0]        cmd_q, cmd_d;
   logic [9:0]         cnt_q, cnt_d;
   logic [15:0]        rsp_q, rsp_d;
   logic [7:0]         frm_cnt_q, frm_cnt_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               clr_q, clr_d;
   logic               snd_q, snd_d;
   logic               busy_q, busy_d;
   logic [NUM_TGT-1:0] req_q, req_d;

   logic [1:0]         idx;
   logic               idx_ok;
   logic [3:0]         ack_pad;
   logic [15:0]        rsp_pad [4];
   logic [7:0]         err_inc;

   assign idx     = cmd_q[23:22];
   assign idx_ok  = (3'(idx) < 3'(NUM_TGT));
   assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   // Pad the target buses to the full 2-bit index range so absent targets read as idle.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_pad
         if (i < NUM_TGT) begin : g_live
            assign ack_pad[i] = bus.tgt_ack[i];
            assign rsp_pad[i] = bus.tgt_rsp[16*i +: 16];
         end else begin : g_tie
            assign ack_pad[i] = 1'b0;
            assign rsp_pad[i] = 16'h0000;
         end
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      rsp_d     = rsp_q;
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      req_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.frm_rdy) begin
               cmd_d     = bus.cfg_data;
               frm_cnt_d = frm_cnt_q + 8'd1;
               state_d   = ST_CLR;
            end
         end
         ST_CLR: begin
            if (idx_ok) begin
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end else begin
               rsp_d     = ERR_TGT;
               err_cnt_d = err_inc;
               state_d   = ST_RESP;
            end
         end
         ST_ISSUE: begin
            cnt_d = cnt_q + 10'd1;
            // An ack landing on the final allowed cycle still counts as success.
            if (ack_pad[idx]) begin
               rsp_d   = rsp_pad[idx];
               state_d = ST_RESP;
            end else if (cnt_q == 10'(TIMEOUT - 1)) begin
               rsp_d     = ERR_TO;
               err_cnt_d = err_inc;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave the flops glitch-free.
      clr_d  = (state_d == ST_CLR);
      snd_d  = (state_d == ST_RESP);
      busy_d = (state_d != ST_IDLE);
      for (int i = 0; i < NUM_TGT; i++) begin
         req_d[i] = (state_d == ST_ISSUE) && (idx == 2'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         cnt_q     <= '0;
         rsp_q     <= '0;
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
         clr_q     <= 1'b0;
         snd_q     <= 1'b0;
         busy_q    <= 1'b0;
         req_q     <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cnt_q     <= cnt_d;
         rsp_q     <= rsp_d;
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
         clr_q     <= clr_d;
         snd_q     <= snd_d;
         busy_q    <= busy_d;
         req_q     <= req_d;
      end
   end

   assign bus.clr_frm_rdy = clr_q;
   assign bus.snd_rsp     = snd_q;
   assign bus.rsp_data    = rsp_q;
   assign bus.tgt_req     = req_q;
   assign bus.tgt_cmd     = cmd_q[21:16];
   assign bus.tgt_data    = cmd_q[15:0];
   assign bus.busy        = busy_q;
   assign bus.frm_cnt     = frm_cnt_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_cmd_dispatch.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_cfg_cmd_dispatch
// Purpose  : Directed plus randomized bench for cfg_cmd_dispatch (4- and 2-target builds).
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_cfg_cmd_dispatch;

   localparam int          NT_A  = 4;
   localparam int          TO_A  = 40;
   localparam int          NT_B  = 2;
   localparam int          TO_B  = 8;
   localparam logic [15:0] E_TGT = 16'hEE01;
   localparam logic [15:0] E_TO  = 16'hEE02;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   int n_chk   = 0;
   int n_fail  = 0;
   int m_frm_a = 0;
   int m_err_a = 0;
   int m_frm_b = 0;
   int m_err_b = 0;

   always #5 clk = ~clk;

   cfg_cmd_dispatch_if #(.NUM_TGT(NT_A)) ifa ();
   cfg_cmd_dispatch_if #(.NUM_TGT(NT_B)) ifb ();

   cfg_cmd_dispatch #(
      .NUM_TGT(NT_A), .TIMEOUT(TO_A), .ERR_TGT(E_TGT), .ERR_TO(E_TO)
   ) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa)
   );

   cfg_cmd_dispatch #(
      .NUM_TGT(NT_B), .TIMEOUT(TO_B), .ERR_TGT(E_TGT), .ERR_TO(E_TO)
   ) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   // One frame on the 4-target build; ack_dly is the ISSUE cycle carrying the ack (<0: never).
   task automatic frame_a(input logic [1:0] idx, input logic [5:0] cmd, input logic [15:0] data,
                          input int ack_dly, input bit stray, input logic [63:0] rsp);
      logic [15:0] exp_rsp;
      logic [3:0]  onehot;
      int exp_k;
      int k         = 0;
      int lat       = 1;
      int lat_snd   = -1;
      int bad_req   = 0;
      int clr_extra = 0;
      bit cmd_ok    = 1'b1;

      onehot = 4'b0001 << idx;
      if (ack_dly >= 0 && ack_dly < TO_A) begin
         exp_rsp = rsp[16*idx +: 16];
         exp_k   = ack_dly + 1;
      end else begin
         exp_rsp = E_TO;
         exp_k   = TO_A;
         m_err_a = sat_inc(m_err_a);
      end
      m_frm_a = (m_frm_a + 1) % 256;

      check("a_idle_before", ifa.busy, 0);
      ifa.tgt_rsp  = rsp;
      ifa.cfg_data = {idx, cmd, data};
      ifa.frm_rdy  = 1'b1;
      @(posedge clk); #1;
      check("a_clr", ifa.clr_frm_rdy, 1);
      check("a_frm_cnt", ifa.frm_cnt, m_frm_a);
      ifa.frm_rdy = 1'b0;

      for (int c = 0; c < TO_A + 8; c++) begin
         @(posedge clk); #1;
         lat++;
         ifa.tgt_ack = '0;
         if (ifa.clr_frm_rdy) clr_extra++;
         if (ifa.snd_rsp) begin
            lat_snd = lat;
            break;
         end
         if (ifa.tgt_req !== '0) begin
            if (ifa.tgt_req !== onehot) bad_req++;
            if (ifa.tgt_cmd !== cmd || ifa.tgt_data !== data) cmd_ok = 1'b0;
            if (k == ack_dly) ifa.tgt_ack[idx] = 1'b1;
            if (stray && idx != 2'd2 && k == 0) ifa.tgt_ack[2] = 1'b1;
            k++;
         end
      end

      check("a_latency", lat_snd, exp_k + 2);
      check("a_req_cycles", k, exp_k);
      check("a_req_onehot", bad_req, 0);
      check("a_cmd_data", cmd_ok, 1);
      check("a_clr_once", clr_extra, 0);
      check("a_req_in_resp", ifa.tgt_req, 0);
      check("a_rsp", ifa.rsp_data, exp_rsp);
      check("a_err_cnt", ifa.err_cnt, m_err_a);
      @(posedge clk); #1;
      check("a_snd_once", ifa.snd_rsp, 0);
      check("a_rsp_hold", ifa.rsp_data, exp_rsp);
      check("a_idle_after", ifa.busy, 0);
   endtask

   // One out-of-range-index frame on the 2-target build.
   task automatic frame_b(input logic [1:0] idx);
      int lat      = 1;
      int lat_snd  = -1;
      int req_seen = 0;

      m_frm_b = (m_frm_b + 1) % 256;
      m_err_b = sat_inc(m_err_b);
      ifb.cfg_data = {idx, 6'($urandom), 16'($urandom)};
      ifb.frm_rdy  = 1'b1;
      @(posedge clk); #1;
      check("b_clr", ifb.clr_frm_rdy, 1);
      ifb.frm_rdy = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         lat++;
         if (ifb.tgt_req !== '0) req_seen++;
         if (ifb.snd_rsp) begin
            lat_snd = lat;
            break;
         end
      end
      check("b_latency", lat_snd, 2);
      check("b_no_req", req_seen, 0);
      check("b_rsp", ifb.rsp_data, E_TGT);
      check("b_frm_cnt", ifb.frm_cnt, m_frm_b);
      check("b_err_cnt", ifb.err_cnt, m_err_b);
      @(posedge clk); #1;
      check("b_snd_once", ifb.snd_rsp, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snd_seen;
      logic [63:0] r;

      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.frm_rdy = 1'b0; ifa.cfg_data = '0; ifa.tgt_ack = '0; ifa.tgt_rsp = '0;
      ifb.frm_rdy = 1'b0; ifb.cfg_data = '0; ifb.tgt_ack = '0; ifb.tgt_rsp = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      check("rst_busy", ifa.busy, 0);
      check("rst_req", ifa.tgt_req, 0);
      check("rst_clr", ifa.clr_frm_rdy, 0);
      check("rst_snd", ifa.snd_rsp, 0);
      check("rst_rsp", ifa.rsp_data, 0);
      check("rst_frm_cnt", ifa.frm_cnt, 0);
      check("rst_err_cnt", ifa.err_cnt, 0);
      check("rst_b_err_cnt", ifb.err_cnt, 0);

      // Basic transaction: idx1, cmd 0x0A, ack two cycles after request.
      frame_a(2'd1, 6'h0A, 16'h1234, 2, 1'b0, {16'h0000, 16'h0000, 16'hBEEF, 16'h0000});

      // Timeout, then ack on the final allowed cycle.
      frame_a(2'd0, 6'h01, 16'hA5A5, -1, 1'b0, 64'h1111_2222_3333_4444);
      frame_a(2'd0, 6'h02, 16'h5A5A, TO_A - 1, 1'b0, 64'h1111_2222_3333_C0DE);

      // Non-selected target acks must be ignored.
      frame_a(2'd0, 6'h03, 16'h0F0F, 3, 1'b1, 64'h0000_DEAD_0000_600D);

      // Reset in the middle of ISSUE.
      ifa.tgt_rsp  = 64'h0;
      ifa.cfg_data = {2'd0, 6'h11, 16'h5555};
      ifa.frm_rdy  = 1'b1;
      @(posedge clk); #1;
      ifa.frm_rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_req", ifa.tgt_req, 4'b0001);
      rst_a = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      m_frm_a = 0;
      m_err_a = 0;
      check("mrst_req", ifa.tgt_req, 0);
      check("mrst_busy", ifa.busy, 0);
      check("mrst_frm_cnt", ifa.frm_cnt, 0);
      check("mrst_err_cnt", ifa.err_cnt, 0);
      check("mrst_rsp", ifa.rsp_data, 0);
      snd_seen = 0;
      for (int c = 0; c < TO_A + 5; c++) begin
         @(posedge clk); #1;
         if (ifa.snd_rsp) snd_seen++;
      end
      check("mrst_no_snd", snd_seen, 0);
      frame_a(2'd3, 6'h3F, 16'hFFFF, 0, 1'b0, 64'h7777_0000_0000_0000);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         int d;
         r = {$urandom, $urandom};
         d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
         frame_a(2'($urandom), 6'($urandom), 16'($urandom), d, 1'($urandom), r);
      end

      // Two-target build: bad index, then wrap/saturation over 300 bad frames.
      frame_b(2'd3);
      for (int n = 1; n < 300; n++) begin
         frame_b(2'($urandom_range(2, 3)));
         if (n == 255) check("b_frm_wrap", ifb.frm_cnt, 0);
      end
      check("b_err_sat", ifb.err_cnt, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
